// File: rtl/dla_mast_fsm_tiled.sv
// dla_mast_fsm_tiled -- master sequencer for the tiled DLA datapath.
//
// Walks one layer as R row passes; each pass is a first-load of SRAM0
// (FSLD) followed by C column tiles: LEFT, BASE x (C-2), RIGHT. The
// address generators and MAC array decode outmast_curr_state directly,
// so the state encoding below is fixed.
//
// Optional build macro: MAST_FSM_ABORT_EN adds an 'abort' input that
// returns any busy state to IDLE with cleared indices.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a layer (only looked at in IDLE)
//   cfg_cols/cfg_rows   tiles per pass / passes per layer, latched on start, 0 -> 1
//   flag_fsld_end       first-load finished (only looked at in FSLD)
//   tile_done           current tile finished (only in LEFT/BASE/RIGHT)
//   abort               (MAST_FSM_ABORT_EN only) cancel the layer
//   outmast_curr_state  current state
//   col_idx, row_idx    0-based tile and pass indices
//   busy                not IDLE
//   layer_done          high for the single DONE cycle
module dla_mast_fsm_tiled #(
   parameter int COL_W      = 8,
   parameter int ROW_W      = 8,
   parameter int STATE_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [COL_W-1:0]      cfg_cols,
   input  logic [ROW_W-1:0]      cfg_rows,
   input  logic                  flag_fsld_end,
   input  logic                  tile_done,
`ifdef MAST_FSM_ABORT_EN
   input  logic                  abort,
`endif
   output logic [STATE_BITS-1:0] outmast_curr_state,
   output logic [COL_W-1:0]      col_idx,
   output logic [ROW_W-1:0]      row_idx,
   output logic                  busy,
   output logic                  layer_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEFT  = 3'd1,
      S_BASE  = 3'd2,
      S_RIGHT = 3'd3,
      S_DONE  = 3'd4,
      S_FSLD  = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d, cols_q, cols_d;
   logic [ROW_W-1:0] row_q, row_d, rows_q, rows_d;
   logic             row_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         cols_q  <= COL_W'(1);
         rows_q  <= ROW_W'(1);
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cols_q  <= cols_d;
         rows_q  <= rows_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cols_d  = cols_q;
      rows_d  = rows_q;
      row_end = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FSLD;
               cols_d  = (cfg_cols == '0) ? COL_W'(1) : cfg_cols;
               rows_d  = (cfg_rows == '0) ? ROW_W'(1) : cfg_rows;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_FSLD: begin
            if (flag_fsld_end) begin
               state_d = S_LEFT;
               col_d   = '0;
            end
         end
         S_LEFT: begin
            if (tile_done) begin
               if (cols_q == COL_W'(1)) begin
                  // single-tile row: LEFT is also the last tile
                  row_end = 1'b1;
               end else begin
                  col_d   = col_q + COL_W'(1);
                  state_d = (cols_q == COL_W'(2)) ? S_RIGHT : S_BASE;
               end
            end
         end
         S_BASE: begin
            if (tile_done) begin
               col_d = col_q + COL_W'(1);
               if (col_d == cols_q - COL_W'(1))
                  state_d = S_RIGHT;
            end
         end
         S_RIGHT: begin
            if (tile_done)
               row_end = 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;  // 5/6 are unreachable encodings
      endcase

      // Last pass finishes the layer; otherwise reload SRAM for the next row.
      if (row_end) begin
         if (row_q == rows_q - ROW_W'(1)) begin
            state_d = S_DONE;
         end else begin
            row_d   = row_q + ROW_W'(1);
            col_d   = '0;
            state_d = S_FSLD;
         end
      end

`ifdef MAST_FSM_ABORT_EN
      // Abort outranks every other input but is meaningless in IDLE.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         col_d   = '0;
         row_d   = '0;
      end
`endif
   end

   assign outmast_curr_state = STATE_BITS'(state_q);
   assign col_idx            = col_q;
   assign row_idx            = row_q;
   assign busy               = (state_q != S_IDLE);
   assign layer_done         = (state_q == S_DONE);

endmodule

// File: doc/dla_mast_fsm_tiled.md
Name: dla_mast_fsm_tiled

Overview:
Parametrised master FSM for the tiled DLA datapath; next generation of the 64-MAC master controller.
- Sequences a full layer of R row-passes × C column-tiles per pass: FSLD (first-load SRAM0) → LEFT → BASE×(C−2) → RIGHT.
- Tracks tile/row indices, reloads between rows, and reports layer completion.
- Sits between the top-level controller (start/config) and the address generators and MAC array, which decode the state output.

Parameters:
COL_W, 8, width of column-tile count/index (max C = 2^COL_W−1)
ROW_W, 8, width of row-pass count/index (max R = 2^ROW_W−1)
STATE_BITS, 3, state output width (fixed encoding below; must be ≥3)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  start layer; sampled only in IDLE
cfg_cols  input  COL_W  column tiles per row pass; latched on accepted start; 0 treated as 1
cfg_rows  input  ROW_W  row passes per layer; latched on accepted start; 0 treated as 1
flag_fsld_end  input  1  first-load complete; honoured only in FSLD
tile_done  input  1  current LEFT/BASE/RIGHT tile complete; honoured only in those states
outmast_curr_state  output  STATE_BITS  current state
col_idx  output  COL_W  current column tile, 0-based
row_idx  output  ROW_W  current row pass, 0-based
busy  output  1  high in every state except IDLE
layer_done  output  1  one-cycle pulse, high exactly while in DONE

Behaviour:
- Single clock (clk); reset synchronous, active-high. All state registers update on posedge clk.
- Reset: state=IDLE, col_idx=0, row_idx=0, latched cfg=1/1, busy=0, layer_done=0. Reset mid-operation aborts immediately; no done pulse.
- Encoding: IDLE=0, LEFT=1, BASE=2, RIGHT=3, DONE=4, FSLD=7; 5 and 6 are illegal and recover to IDLE next cycle.
- Outputs are registered state/counters with no extra latency. Transitions take effect the cycle after the qualifying input.
- IDLE:
  - start=1 → FSLD.
  - Latch cfg_cols/cfg_rows (0→1) and clear col_idx and row_idx.
  - start outside IDLE is ignored.
- FSLD: flag_fsld_end=1 → LEFT, col_idx=0.
- LEFT: on tile_done:
  - C=1 → row-end.
  - C=2 → RIGHT.
  - C≥3 → BASE.
  - In all non-row-end cases, col_idx+1.
- BASE: on tile_done, col_idx+1; if the new col_idx = C−1 → RIGHT, else stay in BASE.
- RIGHT: on tile_done → row-end.
- Row-end:
  - If row_idx = R−1 → DONE.
  - Else row_idx+1, col_idx=0 → FSLD (reload SRAM for next row).
- DONE: unconditional → IDLE next cycle. layer_done=1 for exactly that cycle. col_idx/row_idx hold final values until the next accepted start.
- Boundaries:
  - col_idx never exceeds C−1; row_idx never exceeds R−1. No wrap.
  - Maximum config (all ones) must sequence without overflow.
  - tile_done and flag_fsld_end asserted together: only the one relevant to the current state acts.
  - Held-high inputs advance one step per cycle; there is no edge detection.
  - start asserted in DONE is ignored. It is accepted if still high in the following IDLE cycle.

Optional Feature:
MAST_FSM_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 in any busy state forces IDLE next cycle and clears col_idx/row_idx. No layer_done pulse.
  - abort has priority over all other inputs. abort in IDLE has no effect.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- Reset held 2 cycles, then released → state=0, busy=0, col_idx=0, row_idx=0, layer_done=0.
- cfg_cols=4, cfg_rows=2, start, fsld_end after 3 cycles, tile_done pulses spaced 2 cycles → expected sequence:
  - FSLD, LEFT(c0), BASE(c1), BASE(c2), RIGHT(c3) for row 0.
  - FSLD, LEFT … RIGHT for row 1.
  - DONE with layer_done=1 for one cycle, then IDLE.
- cfg_cols=1, cfg_rows=1 → FSLD, LEFT, DONE, IDLE with no BASE/RIGHT; cfg_cols=2 → LEFT then RIGHT with no BASE.
- cfg_cols=0, cfg_rows=0 → behaves identically to 1/1. start and tile_done asserted during FSLD → state unchanged until fsld_end.
- tile_done held high for 10 cycles with cfg_cols=3, cfg_rows=1 → advances one state per cycle. Synchronous reset asserted while in BASE → IDLE next cycle, no layer_done.
- With MAST_FSM_ABORT_EN: abort in BASE (row 1, col 2) → IDLE next cycle, indices 0, no layer_done; a new start then runs normally.
